fetch_ctrl: RTL and testbench

Instruction-fetch sequencer sitting between the instruction memory (256 × 25-bit words, one-cycle registered read) and the decode stage. It owns the program counter and drives the memory's read address and read strobe. It presents each fetched word to decode over a valid/ready handshake. It also handles control-flow redirects, halts on a designated opcode, and restarts on command.

---
 rtl/fetch_ctrl.sv | 98 +++++++++
 tb/tb_fetch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl: instruction-fetch sequencer between a 256 x 25-bit instruction
// memory (one-cycle registered read) and the decode stage.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               begin/resume fetching (honoured in IDLE and HALT only)
//   mem_rd, mem_addr    read strobe / address to instruction memory
//   mem_data            read data, valid the cycle after mem_rd
//   redirect,
//   redirect_pc         load a new PC, killing any in-flight or held fetch
//   inst_valid, inst,
//   inst_pc             fetched word and its address toward decode
//   inst_ready          decode accepts the held word this cycle
//   busy, halted        status: fetching / stopped on the halt opcode
//   fetch_count         number of accepted instructions (wraps)
// ---------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [7:0] RESET_PC    = 8'h00,
   parameter logic [4:0] HALT_OPCODE = 5'b11111
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        mem_rd,
   output logic [7:0]  mem_addr,
   input  logic [24:0] mem_data,
   input  logic        redirect,
   input  logic [7:0]  redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [24:0] inst,
   output logic [7:0]  inst_pc,
   output logic        busy,
   output logic        halted,
   output logic [15:0] fetch_count
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;

   state_t     state;
   logic [7:0] pc;
   logic       accept;

   assign mem_rd   = (state == REQ);
   assign mem_addr = pc;
   assign busy     = (state == REQ) || (state == WAIT) || (state == HOLD);
   assign halted   = (state == HALT);
   assign accept   = (state == HOLD) && inst_valid && inst_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         inst        <= '0;
         inst_pc     <= '0;
         inst_valid  <= 1'b0;
         fetch_count <= '0;
      end else begin
         // The handshake completes even when a redirect lands in the same
         // cycle; the redirect only decides where fetching goes next.
         if (accept) begin
            fetch_count <= fetch_count + 16'd1;
            inst_valid  <= 1'b0;
         end

         if (redirect) begin
            pc <= redirect_pc;
            if (busy) begin
               // Whatever returns from memory this cycle is simply never latched.
               inst_valid <= 1'b0;
               state      <= REQ;
            end else if (start) begin
               state <= REQ;
            end
         end else begin
            case (state)
               IDLE: if (start) state <= REQ;
               REQ:  state <= WAIT;
               WAIT: begin
                  inst       <= mem_data;
                  inst_pc    <= pc;
                  inst_valid <= 1'b1;
                  pc         <= pc + 8'd1;
                  state      <= HOLD;
               end
               HOLD: begin
                  if (inst_ready)
                     state <= (inst[24:20] == HALT_OPCODE) ? HALT : REQ;
               end
               HALT: if (start) state <= REQ;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1, start = 1'b0, redirect = 1'b0, inst_ready = 1'b0;
   logic [7:0]  redirect_pc = 8'h00;

   logic        mem_rd, inst_valid, busy, halted;
   logic [7:0]  mem_addr, inst_pc;
   logic [24:0] mem_data, inst;
   logic [15:0] fetch_count;

   logic        mem_rd1, inst_valid1, busy1, halted1;
   logic [7:0]  mem_addr1, inst_pc1;
   logic [24:0] mem_data1, inst1;
   logic [15:0] fetch_count1;

   logic [24:0] mem [256];

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Instruction memory: one-cycle registered read, one port per DUT.
   always @(posedge clk) begin
      if (mem_rd)  mem_data  <= mem[mem_addr];
      if (mem_rd1) mem_data1 <= mem[mem_addr1];
   end

   fetch_ctrl dut (
      .clk(clk), .reset(reset), .start(start),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .busy(busy), .halted(halted), .fetch_count(fetch_count)
   );

   fetch_ctrl #(.RESET_PC(8'hFF)) dut_ff (
      .clk(clk), .reset(reset), .start(start),
      .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_data(mem_data1),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid1), .inst_ready(inst_ready), .inst(inst1), .inst_pc(inst_pc1),
      .busy(busy1), .halted(halted1), .fetch_count(fetch_count1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: tracks the fetcher as "is it running", "how old is the
   // outstanding memory read", and "which word is held for decode".
   bit          m_run, m_halt, m_held;
   int          m_age;          // 0: no read outstanding, 1: read issued now, 2: data returns now
   logic [7:0]  m_pc, m_hpc;
   logic [24:0] m_hinst;
   logic [15:0] m_cnt;
   bit          armed = 0;

   task automatic model_step(input bit st, input bit rd, input logic [7:0] rpc,
                             input bit rdy, input bit rs);
      bit acc;
      if (rs) begin
         m_run = 0; m_halt = 0; m_held = 0; m_age = 0;
         m_pc = 8'h00; m_hpc = 8'h00; m_hinst = '0; m_cnt = '0;
         return;
      end
      acc = m_held && rdy;
      if (acc) begin
         m_cnt  = m_cnt + 16'd1;
         m_held = 0;
      end
      if (rd) begin
         m_pc = rpc;
         if (m_run) begin
            m_held = 0; m_age = 1;
         end else if (st) begin
            m_run = 1; m_halt = 0; m_age = 1;
         end
      end else if (!m_run) begin
         if (st) begin
            m_run = 1; m_halt = 0; m_age = 1;
         end
      end else if (m_age == 1) begin
         m_age = 2;
      end else if (m_age == 2) begin
         m_hpc = m_pc; m_hinst = mem[m_pc]; m_held = 1;
         m_pc = m_pc + 8'd1; m_age = 0;
      end else if (acc) begin
         if (m_hinst[24:20] == 5'b11111) begin
            m_run = 0; m_halt = 1;
         end else begin
            m_age = 1;
         end
      end
   endtask

   task automatic check_outputs();
      chk("mem_rd", mem_rd, m_run && (m_age == 1));
      chk("mem_addr", mem_addr, m_pc);
      chk("inst_valid", inst_valid, m_held);
      if (m_held) begin
         chk("inst_pc", inst_pc, m_hpc);
         chk("inst", inst, m_hinst);
      end
      chk("busy", busy, m_run);
      chk("halted", halted, m_halt);
      chk("fetch_count", fetch_count, m_cnt);
   endtask

   // One clock cycle: check what the DUT shows now, drive this cycle's
   // inputs, advance the model across the coming edge.
   task automatic cyc(input bit st, input bit rd, input logic [7:0] rpc,
                      input bit rdy, input bit rs);
      if (armed) check_outputs();
      reset = rs; start = st; redirect = rd; redirect_pc = rpc; inst_ready = rdy;
      model_step(st, rd, rpc, rdy, rs);
      if (rs) armed = 1;
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      repeat (n) cyc(0, 0, 8'h00, 0, 1);
   endtask

   task automatic fill_mem(input int halt_pct);
      logic [24:0] w;
      for (int i = 0; i < 256; i++) begin
         w = 25'($urandom);
         if (int'($urandom_range(0, 99)) < halt_pct) w[24:20] = 5'b11111;
         else w[24:20] = 5'($urandom_range(0, 30));
         mem[i] = w;
      end
   endtask

   logic [24:0] saved;

   initial begin
      @(negedge clk);

      // Straight-line fetch, ready held high; second DUT starts at 8'hFF.
      fill_mem(0);
      do_reset(2);
      chk("rst_inst", inst, 25'd0);
      chk("rst_inst_pc", inst_pc, 8'h00);
      chk("rst_addr_ff", mem_addr1, 8'hFF);
      cyc(1, 0, 8'h00, 1, 0);
      for (int c = 1; c <= 13; c++) begin
         chk("seq_valid", inst_valid, (c % 3 == 0));
         if (c % 3 == 0 && c <= 12) chk("seq_pc", inst_pc, c / 3 - 1);
         if (c == 3) begin chk("ff_valid0", inst_valid1, 1); chk("ff_pc0", inst_pc1, 8'hFF); end
         if (c == 6) begin chk("ff_valid1", inst_valid1, 1); chk("ff_pc1", inst_pc1, 8'h00); end
         if (c == 13) chk("seq_cnt", fetch_count, 16'd4);
         cyc(0, 0, 8'h00, 1, 0);
      end

      // Halt on word 2, then resume at 3.
      fill_mem(0);
      mem[2][24:20] = 5'b11111;
      do_reset(1);
      cyc(1, 0, 8'h00, 1, 0);
      repeat (15) cyc(0, 0, 8'h00, 1, 0);
      chk("halt_halted", halted, 1);
      chk("halt_cnt", fetch_count, 16'd3);
      chk("halt_no_rd", mem_rd, 0);
      cyc(1, 0, 8'h00, 1, 0);
      chk("resume_rd", mem_rd, 1);
      chk("resume_addr", mem_addr, 8'h03);
      repeat (3) cyc(0, 0, 8'h00, 1, 0);

      // Stall in HOLD, then reset while a word is held.
      fill_mem(0);
      do_reset(1);
      cyc(1, 0, 8'h00, 0, 0);
      repeat (3) cyc(0, 0, 8'h00, 0, 0);
      saved = inst;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", inst_valid, 1);
         chk("stall_inst", inst, saved);
         chk("stall_pc", inst_pc, 8'h00);
         chk("stall_no_rd", mem_rd, 0);
         cyc(0, 0, 8'h00, 0, 0);
      end
      chk("stall_cnt", fetch_count, 16'd0);
      cyc(0, 0, 8'h00, 1, 0);
      chk("stall_cnt1", fetch_count, 16'd1);
      chk("stall_drop", inst_valid, 0);
      repeat (2) cyc(0, 0, 8'h00, 0, 0);
      chk("hold2_valid", inst_valid, 1);
      cyc(0, 0, 8'h00, 0, 1);
      chk("rstmid_valid", inst_valid, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_addr", mem_addr, 8'h00);
      chk("rstmid_cnt", fetch_count, 16'd0);
      cyc(0, 0, 8'h00, 0, 0);
      chk("rstmid_no_rd", mem_rd, 0);

      // Redirect during WAIT: stale data dropped, target fetched 3 cycles on.
      do_reset(1);
      cyc(1, 0, 8'h00, 1, 0);
      cyc(0, 0, 8'h00, 1, 0);
      cyc(0, 1, 8'h40, 1, 0);
      chk("redir_valid3", inst_valid, 0);
      chk("redir_rd", mem_rd, 1);
      chk("redir_addr", mem_addr, 8'h40);
      cyc(0, 0, 8'h00, 1, 0);
      chk("redir_valid4", inst_valid, 0);
      cyc(0, 0, 8'h00, 1, 0);
      chk("redir_valid5", inst_valid, 1);
      chk("redir_pc", inst_pc, 8'h40);
      cyc(0, 0, 8'h00, 1, 0);

      // Randomized traffic against the model.
      fill_mem(15);
      do_reset(1);
      for (int i = 0; i < 4000; i++)
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, 8'($urandom),
             $urandom_range(0, 1) == 1, $urandom_range(0, 399) == 0);
      check_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
